// File: rtl/actuation_inv_calc.sv
// ---------------------------------------------------------------------------
// actuation_inv_calc
//   Inverts an actuation law:  d = sat12(a + trunc0((p - c) / b)).
//   One request at a time. The operands are captured at start. The sequence
//   is SUB (signed difference), DIV (22-cycle restoring divide), ADJ (sign,
//   offset, saturate) and DONE (one-cycle done pulse). Latency from the start
//   sample to done is fixed at 24 edges.
//
//   Optional feature: define ACT_INV_ROUND_EN to round the quotient magnitude
//   half-away-from-zero instead of truncating. Latency is unchanged.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   sclr   in   1   synchronous clear, aborts any operation, beats start
//   start  in   1   request, sampled only in IDLE
//   p      in  21   actuation command (unsigned)
//   c      in  20   offset term (unsigned)
//   b      in   8   gain term (unsigned), 0 -> err
//   a      in  12   reference position (unsigned)
//   busy   out  1   high in every state except IDLE
//   done   out  1   one-cycle result-valid pulse
//   err    out  1   divide-by-zero flag, valid with done
//   d      out 12   recovered position, held until the next done
//
// Handshake: start is a request without ready. It is accepted only when
//   busy=0 and ignored otherwise (it is not queued). done pulses exactly
//   once per accepted request unless sclr or rst_n aborts it. d and err are
//   meaningful in the done cycle.
//
// Debug: the FSM state is the internal signal `state` (type state_t).
// ---------------------------------------------------------------------------
module actuation_inv_calc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclr,
   input  logic        start,
   input  logic [20:0] p,
   input  logic [19:0] c,
   input  logic [7:0]  b,
   input  logic [11:0] a,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [11:0] d
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SUB  = 3'd1,
      S_DIV  = 3'd2,
      S_ADJ  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state;

   // captured operands
   logic [20:0] p_r;
   logic [19:0] c_r;
   logic [7:0]  b_r;
   logic [11:0] a_r;

   // divider datapath: q_r starts as |diff| and fills with quotient bits
   // shifted in at the LSB while dividend bits leave at the MSB
   logic        neg_r;
   logic [21:0] q_r;
   logic [7:0]  rem_r;
   logic [4:0]  cnt_r;

   // ---------------- SUB: signed difference and magnitude ----------------
   logic [21:0] diff;
   logic [21:0] diff_abs;

   assign diff     = {1'b0, p_r} - {2'b00, c_r};
   assign diff_abs = diff[21] ? (22'd0 - diff) : diff;

   // ---------------- DIV: one restoring step ----------------
   logic [8:0]  trial;
   logic        q_bit;
   logic [8:0]  trial_sub;

   assign trial     = {rem_r, q_r[21]};
   assign q_bit     = (trial >= {1'b0, b_r});
   assign trial_sub = q_bit ? (trial - {1'b0, b_r}) : trial;

   // ---------------- ADJ: round, sign, offset, saturate ----------------
   logic        round_inc;
   logic [22:0] q_mag;
   logic [23:0] q_signed;
   logic [23:0] sum;
   logic [11:0] d_sat;

`ifdef ACT_INV_ROUND_EN
   // half-away-from-zero on the magnitude: bump when 2*rem >= b
   assign round_inc = ({rem_r, 1'b0} >= {1'b0, b_r});
`else
   assign round_inc = 1'b0;
`endif

   assign q_mag    = {1'b0, q_r} + {22'd0, round_inc};
   assign q_signed = neg_r ? (24'd0 - {1'b0, q_mag}) : {1'b0, q_mag};
   assign sum      = q_signed + {12'd0, a_r};

   always_comb begin
      d_sat = sum[11:0];
      if (sum[23])
         d_sat = 12'd0;
      else if (|sum[22:12])
         d_sat = 12'hFFF;
   end

   // ---------------- FSM with registered outputs ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         d     <= 12'd0;
         p_r   <= 21'd0;
         c_r   <= 20'd0;
         b_r   <= 8'd0;
         a_r   <= 12'd0;
         neg_r <= 1'b0;
         q_r   <= 22'd0;
         rem_r <= 8'd0;
         cnt_r <= 5'd0;
      end else if (sclr) begin
         // abort: d keeps the last good result
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (start) begin
                  p_r   <= p;
                  c_r   <= c;
                  b_r   <= b;
                  a_r   <= a;
                  busy  <= 1'b1;
                  state <= S_SUB;
               end
            end
            S_SUB: begin
               neg_r <= diff[21];
               q_r   <= diff_abs;
               rem_r <= 8'd0;
               cnt_r <= 5'd0;
               state <= S_DIV;
            end
            S_DIV: begin
               q_r   <= {q_r[20:0], q_bit};
               // the remainder stays below b, so 8 bits hold it (b=0 is
               // discarded in ADJ and its remainder is don't-care)
               rem_r <= trial_sub[7:0];
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd21)
                  state <= S_ADJ;
            end
            S_ADJ: begin
               if (b_r == 8'd0) begin
                  err <= 1'b1;
               end else begin
                  err <= 1'b0;
                  d   <= d_sat;
               end
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_actuation_inv_calc.sv
module tb_actuation_inv_calc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sclr;
   logic        start;
   logic [20:0] p;
   logic [19:0] c;
   logic [7:0]  b;
   logic [11:0] a;
   logic        busy;
   logic        done;
   logic        err;
   logic [11:0] d;

   int n_cmp = 0;
   int n_bad = 0;

   actuation_inv_calc dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sclr  (sclr),
      .start (start),
      .p     (p),
      .c     (c),
      .b     (b),
      .a     (a),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .d     (d)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   typedef struct {
      logic [20:0] p;
      logic [19:0] c;
      logic [7:0]  b;
      logic [11:0] a;
      logic [11:0] exp_d;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 12;
   localparam int LAT  = 24;
   vec_t tbl [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scrambles the inputs so a missed capture shows up in the result
   task automatic scramble();
      p = 21'($urandom_range(0, 2097151));
      c = 20'($urandom_range(0, 1048575));
      b = 8'($urandom_range(0, 255));
      a = 12'($urandom_range(0, 4095));
   endtask

   // Called at #1 after a rising edge. Issues one request and follows it to
   // done and one cycle beyond. pulse_mid pulses start during DIV.
   task automatic run_op(input string tag, input vec_t v, input bit pulse_mid);
      int k;
      p = v.p; c = v.c; b = v.b; a = v.a;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      k = 0;
      while (k < 40) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) chk({tag, ".busy"}, busy, 1);
         if (pulse_mid) start = (k == 8);
         if (done) break;
      end
      start = 1'b0;
      chk({tag, ".latency"}, k, LAT);
      chk({tag, ".d"}, d, v.exp_d);
      chk({tag, ".err"}, err, v.exp_err);
      @(posedge clk); #1;
      chk({tag, ".done_width"}, done, 0);
      chk({tag, ".idle_busy"}, busy, 0);
   endtask

   // counts done pulses over n cycles
   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
   endtask

   // kind 0: sclr at DIV cycle 10, kind 1: rst_n pulse at the same point
   task automatic abort_op(input string tag, input vec_t v, input int kind, input logic [11:0] prev_d);
      int cnt;
      p = v.p; c = v.c; b = v.b; a = v.a;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) begin
         @(posedge clk); #1;
      end
      chk({tag, ".busy_before"}, busy, 1);
      if (kind == 0) begin
         sclr  = 1'b1;
         start = 1'b1;           // sclr must win over start
         @(posedge clk); #1;
         sclr  = 1'b0;
         start = 1'b0;
         chk({tag, ".busy"}, busy, 0);
         chk({tag, ".done"}, done, 0);
         chk({tag, ".err"}, err, 0);
         chk({tag, ".d_held"}, d, prev_d);
      end else begin
         #2 rst_n = 1'b0;
         #1;
         chk({tag, ".busy"}, busy, 0);
         chk({tag, ".done"}, done, 0);
         chk({tag, ".d_zero"}, d, 0);
         @(posedge clk); #1;
         rst_n = 1'b1;
      end
      count_done(40, cnt);
      chk({tag, ".no_done"}, cnt, 0);
   endtask

   initial begin
      int cnt;
      logic [11:0] exp_round;
      logic [11:0] exp_neg_half;
`ifdef ACT_INV_ROUND_EN
      exp_round    = 12'd1;
      exp_neg_half = 12'd17;
`else
      exp_round    = 12'd0;
      exp_neg_half = 12'd18;
`endif
      tbl[0]  = '{21'd1400,    20'd1000,    8'd4,   12'd100,  12'd200,  1'b0};
      tbl[1]  = '{21'd1400,    20'd1000,    8'd0,   12'd100,  12'd200,  1'b1};
      tbl[2]  = '{21'd1000,    20'd2000,    8'd8,   12'd500,  12'd375,  1'b0};
      tbl[3]  = '{21'd1003,    20'd1000,    8'd4,   12'd0,    exp_round, 1'b0};
      tbl[4]  = '{21'd1000,    20'd0,       8'd1,   12'd4000, 12'd4095, 1'b0};
      tbl[5]  = '{21'd0,       20'd100,     8'd1,   12'd10,   12'd0,    1'b0};
      tbl[6]  = '{21'd1234,    20'd34,      8'd7,   12'd50,   12'd221,  1'b0};
      tbl[7]  = '{21'd34,      20'd1234,    8'd7,   12'd300,  12'd129,  1'b0};
      tbl[8]  = '{21'd1000,    20'd1010,    8'd4,   12'd20,   exp_neg_half, 1'b0};
      tbl[9]  = '{21'd2097151, 20'd0,       8'd255, 12'd0,    12'd4095, 1'b0};
      tbl[10] = '{21'd0,       20'd1048575, 8'd255, 12'd4095, 12'd0,    1'b0};
      tbl[11] = '{21'd5,       20'd0,       8'd255, 12'd7,    12'd7,    1'b0};

      // ---------------- reset ----------------
      rst_n = 1'b0; sclr = 1'b0; start = 1'b0;
      p = '0; c = '0; b = '0; a = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.err", err, 0);
      chk("reset.d", d, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---------------- table, back-to-back requests ----------------
      for (int i = 0; i < NVEC; i++)
         run_op($sformatf("vec%0d", i), tbl[i], 1'b0);

      // ---------------- start pulsed mid-DIV is ignored ----------------
      run_op("mid_start", tbl[0], 1'b1);
      count_done(40, cnt);
      chk("mid_start.extra_done", cnt, 0);

      // ---------------- reset abort, then a fresh request ----------------
      abort_op("rst_abort", tbl[2], 1, 12'd0);
      run_op("after_rst", tbl[0], 1'b0);

      // ---------------- sclr abort, then a fresh request ----------------
      abort_op("sclr_abort", tbl[6], 0, 12'd200);
      run_op("after_sclr", tbl[2], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // hard stop in case a task hangs on something unforeseen
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
